kbd_matrix_scanner: RTL and testbench



---
 rtl/kbd_matrix_scanner.sv | 237 +++++++++++++++++++++++
 tb/tb_kbd_matrix_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_matrix_scanner.sv
`default_nettype none
// ============================================================================
// kbd_matrix_scanner
// Keypad matrix scanner: row strobes, per-key debounce, key-event FIFO.
// Optional build macro KBD_RELEASE_EVT_EN adds release events (evt_release).
// Revision: 1.0
// ============================================================================
module kbd_matrix_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 8,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      col_n,
  output logic [ROWS-1:0]      row_n,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 any_key,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CW-1:0]        evt_code,
`ifdef KBD_RELEASE_EVT_EN
  output logic                 evt_release,
`endif
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int c_nk  = ROWS * COLS;
  localparam int c_rw  = $clog2(ROWS);
  localparam int c_clw = $clog2(COLS);
  localparam int c_dw  = $clog2(SCAN_DIV);
  localparam int c_aw  = $clog2(FIFO_DEPTH);
`ifdef KBD_RELEASE_EVT_EN
  localparam int c_ew  = CW + 1;
`else
  localparam int c_ew  = CW;
`endif

  // ---------------------------------------------------------------- sync/scan
  logic [COLS-1:0] r_col_s1, r_col_s2;
  logic [c_rw-1:0] r_row;
  logic [c_dw-1:0] r_div;
  logic [ROWS-1:0] r_row_n;
  logic            r_eval;
  logic            w_samp;
  logic            w_last;
  logic [c_rw-1:0] w_row_inc;

  assign w_samp    = (r_div == c_dw'(SCAN_DIV - 2));
  assign w_last    = (r_div == c_dw'(SCAN_DIV - 1));
  assign w_row_inc = r_row + c_rw'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
      r_row    <= '0;
      r_div    <= '0;
      r_row_n  <= ~ROWS'(1);
      r_eval   <= 1'b0;
    end else begin
      r_col_s1 <= col_n;
      r_col_s2 <= r_col_s1;
      r_eval   <= w_samp;
      if (w_last) begin
        r_div <= '0;
        if (r_row == c_rw'(ROWS - 1)) begin
          r_row   <= '0;
          r_row_n <= ~ROWS'(1);
        end else begin
          r_row   <= w_row_inc;
          r_row_n <= ~(ROWS'(1) << w_row_inc);
        end
      end else begin
        r_div <= r_div + c_dw'(1);
      end
    end
  end

  assign row_n = r_row_n;

  // ---------------------------------------------------------------- debounce
  // Evaluation runs the cycle after the sample, while r_row still names the
  // sampled row (the row advances on that same edge).
  logic [c_nk-1:0] r_key, r_any_unused_guard;
  logic [c_nk-1:0] w_rise, w_fall, w_key_nxt;
  logic            r_any;

  for (genvar k = 0; k < c_nk; k++) begin : g_key
    localparam int c_kr = k / COLS;
    localparam int c_kc = k % COLS;
    logic                w_sel;
    logic [DEBOUNCE-1:0] r_hist;

    assign w_sel = (r_row == c_rw'(c_kr));

    if (DEBOUNCE == 1) begin : g_deb1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_hist <= '0;
        else if (w_samp && w_sel) r_hist <= ~r_col_s2[c_kc];
      end
    end else begin : g_debn
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_hist <= '0;
        else if (w_samp && w_sel) r_hist <= {r_hist[DEBOUNCE-2:0], ~r_col_s2[c_kc]};
      end
    end

    assign w_rise[k] = r_eval && w_sel && (&r_hist) && !r_key[k];
    assign w_fall[k] = r_eval && w_sel && !(|r_hist) && r_key[k];
  end

  assign w_key_nxt = (r_key | w_rise) & ~w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
      r_any <= 1'b0;
    end else begin
      r_key <= w_key_nxt;
      r_any <= |w_key_nxt;
    end
  end

  assign r_any_unused_guard = '0;
  assign key_state = r_key | r_any_unused_guard;
  assign any_key   = r_any;

  // ---------------------------------------------------------------- events
  logic [COLS-1:0] w_rise_row, w_fall_row;
  logic [COLS-1:0] r_flip, r_pend;
  logic [c_rw-1:0] r_flip_row, r_pend_row;
  logic [c_clw-1:0] w_col;
  logic [CW-1:0]   w_code;
  logic [c_ew-1:0] w_entry;

  always_comb begin
    w_rise_row = '0;
    w_fall_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_rise_row |= w_rise[r*COLS +: COLS];
      w_fall_row |= w_fall[r*COLS +: COLS];
    end
  end

`ifdef KBD_RELEASE_EVT_EN
  logic [COLS-1:0] r_flip_rel, r_pend_rel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flip_rel <= '0;
      r_pend_rel <= '0;
    end else begin
      r_flip_rel <= w_fall_row;
      if (|r_flip) r_pend_rel <= r_flip_rel;
    end
  end
`endif

  // r_flip is non-zero only in the cycle after evaluation, and the previous
  // row's mask has drained by then, so OR-loading needs no arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flip     <= '0;
      r_flip_row <= '0;
      r_pend     <= '0;
      r_pend_row <= '0;
    end else begin
`ifdef KBD_RELEASE_EVT_EN
      r_flip     <= w_rise_row | w_fall_row;
`else
      r_flip     <= w_rise_row;
`endif
      r_flip_row <= r_row;
      r_pend     <= (r_pend & (r_pend - COLS'(1))) | r_flip;
      if (|r_flip) r_pend_row <= r_flip_row;
    end
  end

  always_comb begin
    w_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (r_pend[c]) w_col = c_clw'(c);
    end
  end

  assign w_code = CW'(r_pend_row) * CW'(COLS) + CW'(w_col);
`ifdef KBD_RELEASE_EVT_EN
  assign w_entry = {r_pend_rel[w_col], w_code};
`else
  assign w_entry = w_code;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [c_ew-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]   r_wp, r_rp;
  logic            r_ovf;
  logic            w_empty, w_full, w_push, w_pop, w_wr, w_drop;
  logic [c_ew-1:0] w_head;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[c_aw] != r_rp[c_aw]) && (r_wp[c_aw-1:0] == r_rp[c_aw-1:0]);
  assign w_push  = |r_pend;
  assign w_pop   = !w_empty && evt_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp[c_aw-1:0]] <= w_entry;
        r_wp <= r_wp + (c_aw + 1)'(1);
      end
      if (w_pop) r_rp <= r_rp + (c_aw + 1)'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign w_head    = r_mem[r_rp[c_aw-1:0]];
  assign evt_valid = !w_empty;
  assign evt_code  = w_head[CW-1:0];
`ifdef KBD_RELEASE_EVT_EN
  assign evt_release = w_head[CW];
`endif
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_kbd_matrix_scanner.sv
`default_nettype none
// Directed bench for kbd_matrix_scanner (4x4, SCAN_DIV 8, DEBOUNCE 3, FIFO 4),
// driving a simple keypad model from row_n.
module tb_kbd_matrix_scanner;
  localparam int FRAME = 32;
`ifdef KBD_RELEASE_EVT_EN
  localparam int REL = 1;
`else
  localparam int REL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n, row_n, evt_code;
  logic [15:0] key_state;
  logic        any_key, evt_valid, evt_ready, overflow, ovf_clr, evt_release;
  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          keys [5] = '{5, 0, 10, 15, 3};
  logic [4:0]  ev_q [$];
  int          ev_cyc [$];

  kbd_matrix_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .key_state(key_state), .any_key(any_key),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
`ifdef KBD_RELEASE_EVT_EN
    .evt_release(evt_release),
`endif
    .overflow(overflow), .ovf_clr(ovf_clr)
  );
`ifndef KBD_RELEASE_EVT_EN
  assign evt_release = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    col_n = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      ev_q.push_back({evt_release, evt_code});
      ev_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_key(input int k, input logic v, input string tag);
    int n;
    n = 0;
    while (key_state[k] !== v && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, key_state[k]}, {31'd0, v});
  endtask

  function automatic logic [4:0] evq(input int i);
    return (i < ev_q.size()) ? ev_q[i] : 5'h1f;
  endfunction

  initial begin
    int t0, n, seen, gap;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    pressed   = '0;

    // reset state
    tick(3);
    check("rst_row_n", row_n, 4'he);
    check("rst_key_state", key_state, 0);
    check("rst_any_key", any_key, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_code", evt_code, 0);
    check("rst_evt_release", evt_release, 0);
    check("rst_overflow", overflow, 0);

    // row dwell and advance
    rst = 1'b0;
    tick(7);
    check("dwell_row0", row_n, 4'he);
    tick(1);
    check("advance_row1", row_n, 4'hd);

    // asynchronous reset mid-scan
    tick(5);
    #2 rst = 1'b1;
    #1 check("async_rst_row_n", row_n, 4'he);
    tick(2);
    check("rst_hold_row_n", row_n, 4'he);
    check("rst_hold_valid", evt_valid, 0);
    rst = 1'b0;
    tick(1);
    check("post_rst_row_n", row_n, 4'he);
    check("post_rst_key_state", key_state, 0);
    check("post_rst_valid", evt_valid, 0);
    check("post_rst_overflow", overflow, 0);

    // single key row 2 col 1 (code 9)
    ev_q.delete(); ev_cyc.delete();
    pressed[9] = 1'b1;
    wait_key(9, 1'b1, "press9_state");
    t0 = cyc;
    n = 0;
    while (!evt_valid && n < 10) begin
      tick(1);
      n++;
    end
    check("press9_evt_latency", cyc - t0, 2);
    check("press9_head_code", evt_code, 9);
    check("press9_any_key", any_key, 1);
    tick(2 * FRAME);
    check("press9_evt_count", ev_q.size(), 1);
    check("press9_evt", evq(0), 5'h09);
    ev_q.delete(); ev_cyc.delete();
    pressed[9] = 1'b0;
    wait_key(9, 1'b0, "release9_state");
    tick(8);
    check("release9_any_key", any_key, 0);
    check("release9_evt_count", ev_q.size(), REL);
`ifdef KBD_RELEASE_EVT_EN
    check("release9_evt", evq(0), 5'h19);
`endif

    // key 7 bouncing once per frame never settles
    ev_q.delete(); ev_cyc.delete();
    seen = 0;
    pressed[7] = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        tick(1);
        if (key_state[7]) seen = 1;
      end
      pressed[7] = ~pressed[7];
    end
    pressed[7] = 1'b0;
    tick(FRAME);
    check("bounce_never_set", seen, 0);
    check("bounce_key_state", key_state, 0);
    check("bounce_evt_count", ev_q.size(), 0);

    // two keys in one row: events 4 then 6 on consecutive cycles
    ev_q.delete(); ev_cyc.delete();
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    wait_key(6, 1'b1, "press6_state");
    tick(12);
    check("press4_state", key_state[4], 1);
    check("pair_evt_count", ev_q.size(), 2);
    check("pair_evt0", evq(0), 5'h04);
    check("pair_evt1", evq(1), 5'h06);
    gap = (ev_cyc.size() >= 2) ? ev_cyc[1] - ev_cyc[0] : -1;
    check("pair_evt_gap", gap, 1);
    ev_q.delete(); ev_cyc.delete();
    pressed[4] = 1'b0;
    pressed[6] = 1'b0;
    wait_key(4, 1'b0, "release4_state");
    wait_key(6, 1'b0, "release6_state");
    tick(12);
    check("pair_release_evt_count", ev_q.size(), 2 * REL);

    // FIFO fill with consumer stalled, fifth event dropped
    ev_q.delete(); ev_cyc.delete();
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pressed[keys[i]] = 1'b1;
      wait_key(keys[i], 1'b1, "fill_press_state");
      tick(6);
      if (i == 0) check("fill_first_valid", evt_valid, 1);
      if (i == 3) check("fill_full_no_ovf", overflow, 0);
    end
    check("fill_overflow", overflow, 1);
    check("fill_head_stable", evt_code, 5);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    tick(8);
    check("drain_count", ev_q.size(), 4);
    check("drain_evt0", evq(0), 5'h05);
    check("drain_evt1", evq(1), 5'h00);
    check("drain_evt2", evq(2), 5'h0a);
    check("drain_evt3", evq(3), 5'h0f);
    check("drain_empty", evt_valid, 0);
    ev_q.delete(); ev_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      pressed[keys[i]] = 1'b0;
      wait_key(keys[i], 1'b0, "fill_release_state");
      tick(6);
    end
    check("fill_release_evt_count", ev_q.size(), 5 * REL);
    check("final_overflow", overflow, 0);
    check("final_any_key", any_key, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
